// File: rtl/serial_add_frontend.sv
// Operand serialiser / result deserialiser that sits around a 1-bit serial adder.
// Optional one-entry operand skid buffer is enabled by defining SERIAL_ADD_FRONTEND_SKID_EN.
module serial_add_frontend #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             sum_bit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic [CntW-1:0]   cnt_q;
  logic              accept;
  logic              last_bit;

`ifdef SERIAL_ADD_FRONTEND_SKID_EN
  logic              buf_full_q;
  logic [WIDTH-1:0]  buf_a_q, buf_b_q;
`endif

  always_comb begin
    ser_valid = (state_q == StShift);
    ser_first = ser_valid && (cnt_q == '0);
    ser_a     = ser_valid & a_q[0];
    ser_b     = ser_valid & b_q[0];
    res_valid = (state_q == StDone);
    res       = res_q;
`ifdef SERIAL_ADD_FRONTEND_SKID_EN
    in_ready  = !buf_full_q;
`else
    in_ready  = (state_q == StIdle);
`endif
    accept    = in_valid && in_ready;
    last_bit  = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
`ifdef SERIAL_ADD_FRONTEND_SKID_EN
      buf_full_q <= 1'b0;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          res_q <= {sum_bit, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CntW'(1);
          if (last_bit) state_q <= StDone;
`ifdef SERIAL_ADD_FRONTEND_SKID_EN
          if (accept) begin
            buf_full_q <= 1'b1;
            buf_a_q    <= in_a;
            buf_b_q    <= in_b;
          end
`endif
        end
        StDone: begin
          if (res_ready) begin
`ifdef SERIAL_ADD_FRONTEND_SKID_EN
            // Buffered pair goes first; a pair arriving now skips the buffer.
            if (buf_full_q) begin
              buf_full_q <= 1'b0;
              a_q        <= buf_a_q;
              b_q        <= buf_b_q;
              cnt_q      <= '0;
              state_q    <= StShift;
            end else if (accept) begin
              a_q        <= in_a;
              b_q        <= in_b;
              cnt_q      <= '0;
              state_q    <= StShift;
            end else begin
              state_q    <= StIdle;
            end
`else
            state_q <= StIdle;
`endif
          end
`ifdef SERIAL_ADD_FRONTEND_SKID_EN
          else if (accept) begin
            buf_full_q <= 1'b1;
            buf_a_q    <= in_a;
            buf_b_q    <= in_b;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_frontend.sv
// Self-checking bench for serial_add_frontend (WIDTH=8) with a behavioural serial adder
// and a queue-based reference of expected sums.
module tb_serial_add_frontend;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         ser_valid, ser_first, ser_a, ser_b, sum_bit;
  logic         res_valid, res_ready;
  logic [W-1:0] res;

  int checks = 0;
  int errors = 0;

  serial_add_frontend #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .ser_valid(ser_valid), .ser_first(ser_first), .ser_a(ser_a), .ser_b(ser_b),
    .sum_bit(sum_bit),
    .res_valid(res_valid), .res_ready(res_ready), .res(res)
  );

  always #5 clk = ~clk;

  // Environment: serial adder whose carry is ignored on the first bit of a word.
  logic carry_q = 1'b0;
  logic cin;
  assign cin     = ser_first ? 1'b0 : carry_q;
  assign sum_bit = ser_a ^ ser_b ^ cin;
  always @(posedge clk)
    if (ser_valid) carry_q <= (ser_a & ser_b) | (ser_a & cin) | (ser_b & cin);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_pair(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 100) begin step(); n++; end
    ok = in_ready;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    int n = 0;
    while (!res_valid && n < 100) begin step(); n++; end
    ok = res_valid;
  endtask

  task automatic pulse_ready;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [6:0] got;
    got = {in_ready, ser_valid, ser_first, ser_a, ser_b, res_valid, |res};
    checks++;
    if (got !== 7'b1000000) begin
      errors++;
      $display("FAIL %s: outputs {rdy,sv,sf,sa,sb,rv,|res} got %b want 1000000", tag, got);
    end
    checks++;
    if (res !== 8'h00) begin
      errors++;
      $display("FAIL %s res: got %h want 00", tag, res);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic;
    logic [W-1:0] a = 8'h1B, b = 8'h25;
    in_valid = 1'b1; in_a = a; in_b = b;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      checks++;
      if ({ser_valid, ser_first, ser_a, ser_b, res_valid} !==
          {1'b1, (k == 0), a[k], b[k], 1'b0}) begin
        errors++;
        $display("FAIL basic_bit%0d: {sv,sf,sa,sb,rv} got %b want %b", k,
                 {ser_valid, ser_first, ser_a, ser_b, res_valid},
                 {1'b1, (k == 0), a[k], b[k], 1'b0});
      end
      step();
    end
    checks++;
    if (res_valid !== 1'b1 || res !== 8'h40) begin
      errors++;
      $display("FAIL basic_result: rv=%b res=%h want rv=1 res=40", res_valid, res);
    end
    pulse_ready();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_back_idle: rv=%b rdy=%b sv=%b want 0 1 0", res_valid, in_ready, ser_valid);
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] av[2] = '{8'hFF, 8'h00};
    logic [W-1:0] bv[2] = '{8'h01, 8'h00};
    bit ok, ok2;
    for (int i = 0; i < 2; i++) begin
      accept_pair(av[i], bv[i], ok);
      wait_res(ok2);
      checks++;
      if (!ok || !ok2 || res !== 8'h00) begin
        errors++;
        $display("FAIL wrap%0d: ok=%0d/%0d res=%h want 00", i, ok, ok2, res);
      end
      pulse_ready();
    end
  endtask

  task automatic test_backpressure;
    bit ok, ok2;
    accept_pair(8'h5A, 8'h3C, ok);
    wait_res(ok2);
    for (int i = 0; i < 5; i++) begin
      checks++;
`ifdef SERIAL_ADD_FRONTEND_SKID_EN
      if (!ok || !ok2 || res_valid !== 1'b1 || res !== 8'h96 || in_ready !== 1'b1) begin
`else
      if (!ok || !ok2 || res_valid !== 1'b1 || res !== 8'h96 || in_ready !== 1'b0) begin
`endif
        errors++;
        $display("FAIL backpressure%0d: rv=%b res=%h rdy=%b want rv=1 res=96", i,
                 res_valid, res, in_ready);
      end
      step();
    end
    pulse_ready();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: rv=%b rdy=%b want 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, ok2;
    accept_pair(8'hAA, 8'h55, ok);
    repeat (4) step();
    checks++;
    if (!ok || ser_valid !== 1'b1 || ser_first !== 1'b0) begin
      errors++;
      $display("FAIL midword_active: sv=%b sf=%b want 1 0", ser_valid, ser_first);
    end
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset_mid_word");
    step();
    #2 rst = 1'b1;
    step();
    accept_pair(8'h03, 8'h04, ok);
    wait_res(ok2);
    checks++;
    if (!ok || !ok2 || res !== 8'h07) begin
      errors++;
      $display("FAIL after_reset_add: res=%h want 07", res);
    end
    pulse_ready();
  endtask

`ifdef SERIAL_ADD_FRONTEND_SKID_EN
  task automatic test_skid;
    logic [W-1:0] av[3] = '{8'd1, 8'd3, 8'd250};
    logic [W-1:0] bv[3] = '{8'd2, 8'd4, 8'd10};
    logic [W-1:0] want[3] = '{8'h03, 8'h07, 8'h04};
    int idx = 0, nres = 0, last_hs = -10;
    bit pv = 0, pr = 0;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && nres < 3; cyc++) begin
      if (pv && pr) idx++;
      if (ser_first && nres >= 1) begin
        checks++;
        if (cyc != last_hs + 1) begin
          errors++;
          $display("FAIL skid_start%0d: started cycle %0d want %0d", nres, cyc, last_hs + 1);
        end
      end
      in_valid = (idx < 3);
      in_a = (idx < 3) ? av[idx] : '0;
      in_b = (idx < 3) ? bv[idx] : '0;
      if (res_valid) begin
        checks++;
        if (res !== want[nres]) begin
          errors++;
          $display("FAIL skid_res%0d: got %h want %h", nres, res, want[nres]);
        end
        nres++;
        last_hs = cyc;
      end
      pv = in_valid; pr = in_ready;
      step();
    end
    in_valid = 1'b0; res_ready = 1'b0;
    checks++;
    if (nres != 3) begin errors++; $display("FAIL skid_count: got %0d want 3", nres); end
  endtask
`endif

  task automatic test_random;
    localparam int N = 1000;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pa = '0, pb = '0, hold_res = '0, want;
    bit pv = 0, pr = 0, hold = 0;
    int acc = 0, got = 0, cyc = 0;
    while ((acc < N || exp_q.size() > 0) && cyc < 60000) begin
      if (pv && pr) begin exp_q.push_back(8'(pa + pb)); acc++; end
      if (hold) begin
        checks++;
        if (res_valid !== 1'b1 || res !== hold_res) begin
          errors++;
          $display("FAIL rand_hold: rv=%b res=%h want 1 %h", res_valid, res, hold_res);
        end
      end
      if (!ser_valid && (ser_a || ser_b || ser_first)) begin
        errors++;
        $display("FAIL rand_ser_idle: sa=%b sb=%b sf=%b want 0", ser_a, ser_b, ser_first);
      end
      checks++;
      in_valid  = (acc < N) && ($urandom_range(0, 9) < 7);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: unexpected result %h", res);
        end else begin
          want = exp_q.pop_front();
          if (res !== want) begin
            errors++;
            $display("FAIL rand_res%0d: got %h want %h", got, res, want);
          end
        end
        got++;
      end
      hold = res_valid && !res_ready;
      hold_res = res;
      pv = in_valid; pr = in_ready; pa = in_a; pb = in_b;
      step();
      cyc++;
    end
    in_valid = 1'b0; res_ready = 1'b0;
    checks++;
    if (cyc >= 60000 || acc != N || got != N) begin
      errors++;
      $display("FAIL rand_counts: in=%0d out=%0d want %0d each (cycles %0d)", acc, got, N, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid();
`ifdef SERIAL_ADD_FRONTEND_SKID_EN
    test_skid();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
